// File: rtl/agen_pkg.sv
// Shared constants for the address generation stage:
// segment numbers, operand modes, ModR/M field codes, register indices.
package agen_pkg;

   localparam logic [2:0] SEG_ES = 3'd0;
   localparam logic [2:0] SEG_CS = 3'd1;
   localparam logic [2:0] SEG_SS = 3'd2;
   localparam logic [2:0] SEG_DS = 3'd3;
   localparam logic [2:0] SEG_FS = 3'd4;
   localparam logic [2:0] SEG_GS = 3'd5;

   localparam logic [2:0] OP_MODE_REG = 3'd1;
   localparam logic [2:0] OP_MODE_RM  = 3'd4;

   localparam logic [2:0] REG_ESP = 3'd4;
   localparam logic [2:0] REG_EBP = 3'd5;

   localparam logic [2:0] RM_SIB     = 3'd4;
   localparam logic [2:0] RM_DISP32  = 3'd5;
   localparam logic [2:0] IDX_NONE   = 3'd4;
   localparam logic [1:0] MOD_NODISP = 2'b00;
   localparam logic [1:0] MOD_REG    = 2'b11;

   // Segment numbers 6 and 7 do not exist; treat them as DS.
   function automatic logic [2:0] seg_fold(input logic [2:0] s);
      return (s > SEG_GS) ? SEG_DS : s;
   endfunction

endpackage

// File: rtl/agen_ea_calc.sv
// Combinational 32-bit ModR/M + SIB effective address and default segment.
// Ports: mod_f/rm/sib/disp/gpr in; ea, def_seg (SS for ESP/EBP base, else DS) out.
module agen_ea_calc
   import agen_pkg::*;
(
   input  logic [1:0]   mod_f,
   input  logic [2:0]   rm,
   input  logic [7:0]   sib,
   input  logic [31:0]  disp,
   input  logic [255:0] gpr,
   output logic [31:0]  ea,
   output logic [2:0]   def_seg
);

   logic [7:0][31:0] regs;
   logic [2:0]       base_sel;
   logic             has_base;
   logic [31:0]      base_v;
   logic [31:0]      idx_v;
   logic [31:0]      disp_v;

   assign regs = gpr;

   always_comb begin
      has_base = 1'b1;
      base_sel = rm;
      idx_v    = '0;
      disp_v   = (mod_f == MOD_NODISP) ? 32'd0 : disp;
      unique case (1'b1)
         (rm == RM_SIB): begin
            // SIB base 101 under mod 00 is "no base, disp32".
            has_base = !((sib[2:0] == RM_DISP32) &&
                         (mod_f == MOD_NODISP));
            base_sel = sib[2:0];
            if (sib[5:3] != IDX_NONE)
               idx_v = regs[sib[5:3]] << sib[7:6];
            if (!has_base)
               disp_v = disp;
         end
         ((rm == RM_DISP32) && (mod_f == MOD_NODISP)): begin
            has_base = 1'b0;
            disp_v   = disp;
         end
         default: begin
            has_base = 1'b1;
         end
      endcase
      base_v  = has_base ? regs[base_sel] : 32'd0;
      ea      = base_v + idx_v + disp_v;
      def_seg = (has_base && ((base_sel == REG_ESP) ||
                              (base_sel == REG_EBP)))
                ? SEG_SS : SEG_DS;
   end

endmodule

// File: rtl/address_generation_stage.sv
// Address generation stage: EA + segment-relocated linear address, registered
// behind valid/ready. Ports: clk, reset (sync, high), flush; r_* upstream bundle
// with r_valid/r_ready; a_* downstream result with a_valid/a_ready.
// Option: AGEN_SKID_BUFFER_EN selects a 2-entry skid buffer with registered r_ready.
module address_generation_stage
   import agen_pkg::*;
#(
   parameter int SIDEBAND_W = 128,
   parameter int SEG_SHIFT  = 4
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  r_valid,
   output logic                  r_ready,
   input  logic [2:0]            r_op0,
   input  logic [2:0]            r_op1,
   input  logic [7:0]            r_modrm,
   input  logic [7:0]            r_sib,
   input  logic [31:0]           r_disp,
   input  logic [2:0]            r_seg_override,
   input  logic                  r_seg_override_valid,
   input  logic [255:0]          r_gpr,
   input  logic [95:0]           r_seg,
   input  logic [SIDEBAND_W-1:0] r_sideband,
   output logic                  a_valid,
   input  logic                  a_ready,
   output logic                  a_mem,
   output logic                  a_mem_slot,
   output logic [2:0]            a_seg_num,
   output logic [31:0]           a_ea,
   output logic [31:0]           a_linear,
   output logic [SIDEBAND_W-1:0] a_sideband
);

   localparam int EW = SIDEBAND_W + 69;
   localparam logic [EW-1:0] RST_ENTRY =
      {1'b0, 1'b0, SEG_DS, 32'd0, 32'd0, {SIDEBAND_W{1'b0}}};

   logic [5:0][15:0] segs;
   logic [31:0]      ea_raw;
   logic [2:0]       def_seg;
   logic             mem0;
   logic             mem1;
   logic             in_mem;
   logic             in_slot;
   logic [2:0]       seg_sel;
   logic [31:0]      seg_base;
   logic [31:0]      in_ea;
   logic [31:0]      in_lin;
   logic [EW-1:0]    in_entry;
   logic [EW-1:0]    out_q;
   logic             accept;
   logic             unused_reg_field;

   assign segs             = r_seg;
   assign unused_reg_field = ^r_modrm[5:3];

   agen_ea_calc u_ea_calc (
      .mod_f   (r_modrm[7:6]),
      .rm      (r_modrm[2:0]),
      .sib     (r_sib),
      .disp    (r_disp),
      .gpr     (r_gpr),
      .ea      (ea_raw),
      .def_seg (def_seg)
   );

   always_comb begin
      mem0     = (r_op0 == OP_MODE_RM) && (r_modrm[7:6] != MOD_REG);
      mem1     = (r_op1 == OP_MODE_RM) && (r_modrm[7:6] != MOD_REG);
      in_mem   = mem0 | mem1;
      in_slot  = !mem0 & mem1;
      seg_sel  = r_seg_override_valid ? seg_fold(r_seg_override)
                                      : def_seg;
      seg_base = 32'(segs[seg_sel]) << SEG_SHIFT;
      in_ea    = in_mem ? ea_raw : 32'd0;
      in_lin   = in_mem ? (seg_base + ea_raw) : 32'd0;
      in_entry = {in_mem, in_slot, seg_sel, in_ea, in_lin, r_sideband};
   end

   assign accept = r_valid & r_ready;

   assign {a_mem, a_mem_slot, a_seg_num, a_ea, a_linear, a_sideband} = out_q;

`ifdef AGEN_SKID_BUFFER_EN

   logic [EW-1:0] skid_q;
   logic          skid_v;

   // Upstream sees only the skid occupancy, never a_ready.
   assign r_ready = !skid_v;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_valid <= 1'b0;
         out_q   <= RST_ENTRY;
         skid_v  <= 1'b0;
         skid_q  <= RST_ENTRY;
      end else if (flush) begin
         a_valid <= 1'b0;
         skid_v  <= 1'b0;
      end else if (!a_valid || a_ready) begin
         if (skid_v) begin
            out_q   <= skid_q;
            a_valid <= 1'b1;
            skid_v  <= 1'b0;
         end else if (accept) begin
            out_q   <= in_entry;
            a_valid <= 1'b1;
         end else begin
            a_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_q <= in_entry;
         skid_v <= 1'b1;
      end
   end

`else

   assign r_ready = !a_valid | a_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_valid <= 1'b0;
         out_q   <= RST_ENTRY;
      end else if (flush) begin
         a_valid <= 1'b0;
      end else if (accept) begin
         out_q   <= in_entry;
         a_valid <= 1'b1;
      end else if (a_ready) begin
         a_valid <= 1'b0;
      end
   end

`endif

endmodule
